uart_mmio: RTL and testbench

- Memory-mapped 8N1 UART controller on the CPU data bus, downstream of the single-cycle core.
- Serves loads and stores the core steers to peripheral space (address bit 30 set).
- Provides a transmit shifter, a receive deserializer with a 4-entry RX FIFO, and status/control registers.
- Drives a level interrupt request to the core's interrupt logic.

---
 rtl/uart_mmio.sv | 251 +++++++++++++++++++++++++
 tb/tb_uart_mmio.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART for the core's peripheral space.
// Contains a transmit shifter, a receive deserializer feeding a small RX FIFO,
// and a status/control register with sticky event bits and a level IRQ.
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-low reset
//   rd/wr  bus strobes, already qualified by the peripheral-space decode
//   addr   byte address (full 32-bit compare against the register map)
//   wdata  store data (only [7:0] / [1:0] are used)
//   rdata  load data, combinational from addr (no rd gating)
//   irq    registered level interrupt request
//   tx     serial out, idle high
//   rx     serial in, asynchronous to clk
//
// Register map:
//   0x40000018 TXD  W: start TX of [7:0] when idle.  R: last accepted byte
//   0x4000001C RXD  R: FIFO head (0 if empty), the read pops.  W: ignored
//   0x40000020 CON  [0] tx_irq_en  [1] rx_irq_en  [2] tx_done  [3] rx_avail
//                   [4] tx_busy    [5] rx_overrun
module uart_mmio #(
   parameter int BAUD_DIV   = 5208,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rd,
   input  logic        wr,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq,
   output logic        tx,
   input  logic        rx
);
   localparam int CW = $clog2(BAUD_DIV);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   // address decode
   logic sel_txd, sel_rxd, sel_con;
   assign sel_txd = (addr == 32'h4000_0018);
   assign sel_rxd = (addr == 32'h4000_001C);
   assign sel_con = (addr == 32'h4000_0020);

   logic unused_wdata;
   assign unused_wdata = ^wdata[31:8];

   // control / status
   logic tx_irq_en, rx_irq_en, tx_done, rx_overrun;
   logic con_rd;
   assign con_rd = rd && sel_con;

   // ---------------- TX ----------------
   state_t          tx_st, tx_st_n;
   logic [CW-1:0]   tx_cnt, tx_cnt_n;
   logic [2:0]      tx_bit, tx_bit_n;
   logic [7:0]      tx_byte;
   logic            tx_accept, tx_done_set, tx_d, tx_busy;

   assign tx_busy = (tx_st != S_IDLE);

   always_comb begin
      tx_st_n     = tx_st;
      tx_cnt_n    = tx_cnt;
      tx_bit_n    = tx_bit;
      tx_accept   = 1'b0;
      tx_done_set = 1'b0;
      case (tx_st)
         S_IDLE:
            if (wr && sel_txd) begin
               tx_accept = 1'b1;
               tx_st_n   = S_START;
               tx_cnt_n  = '0;
            end
         S_START:
            if (tx_cnt == BIT_LAST) begin
               tx_cnt_n = '0;
               tx_bit_n = '0;
               tx_st_n  = S_DATA;
            end else tx_cnt_n = tx_cnt + 1'b1;
         S_DATA:
            if (tx_cnt == BIT_LAST) begin
               tx_cnt_n = '0;
               if (tx_bit == 3'd7) tx_st_n = S_STOP;
               else                tx_bit_n = tx_bit + 3'd1;
            end else tx_cnt_n = tx_cnt + 1'b1;
         S_STOP:
            if (tx_cnt == BIT_LAST) begin
               tx_cnt_n    = '0;
               tx_st_n     = S_IDLE;
               tx_done_set = 1'b1;
            end else tx_cnt_n = tx_cnt + 1'b1;
         default: tx_st_n = S_IDLE;
      endcase
      // line level is decoded from the next state so the tx flop changes on
      // the same edge as the state (start bit appears on the accepting edge)
      case (tx_st_n)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = tx_byte[tx_bit_n];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_st  <= S_IDLE;
         tx_cnt <= '0;
         tx_bit <= '0;
      end else begin
         tx_st  <= tx_st_n;
         tx_cnt <= tx_cnt_n;
         tx_bit <= tx_bit_n;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx      <= 1'b1;
         tx_byte <= '0;
      end else begin
         tx <= tx_d;
         if (tx_accept) tx_byte <= wdata[7:0];
      end
   end

   // ---------------- RX ----------------
   logic            rx_meta, rx_s;
   state_t          rx_st, rx_st_n;
   logic [CW-1:0]   rx_cnt, rx_cnt_n;
   logic [2:0]      rx_bit, rx_bit_n;
   logic [7:0]      rx_sh, rx_sh_n;

   // FIFO
   logic [7:0]  fifo_mem [FIFO_DEPTH];
   logic [AW:0] wp, rp;
   logic        empty, full, push, pop, overrun_set;

   assign empty = (wp == rp);
   assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign pop   = rd && sel_rxd && !empty;

   always_comb begin
      rx_st_n     = rx_st;
      rx_cnt_n    = rx_cnt;
      rx_bit_n    = rx_bit;
      rx_sh_n     = rx_sh;
      push        = 1'b0;
      overrun_set = 1'b0;
      case (rx_st)
         S_IDLE:
            if (!rx_s) begin
               rx_st_n  = S_START;
               rx_cnt_n = '0;
            end
         S_START:
            // half a bit later: still low means a real start bit
            if (rx_cnt == HALF_LAST) begin
               rx_cnt_n = '0;
               rx_bit_n = '0;
               rx_st_n  = rx_s ? S_IDLE : S_DATA;
            end else rx_cnt_n = rx_cnt + 1'b1;
         S_DATA:
            if (rx_cnt == BIT_LAST) begin
               rx_cnt_n = '0;
               rx_sh_n  = {rx_s, rx_sh[7:1]};
               if (rx_bit == 3'd7) rx_st_n = S_STOP;
               else                rx_bit_n = rx_bit + 3'd1;
            end else rx_cnt_n = rx_cnt + 1'b1;
         S_STOP:
            if (rx_cnt == BIT_LAST) begin
               rx_cnt_n = '0;
               rx_st_n  = S_IDLE;
               // a low stop bit is a framing error: drop silently
               if (rx_s) begin
                  if (!full || pop) push = 1'b1;
                  else              overrun_set = 1'b1;
               end
            end else rx_cnt_n = rx_cnt + 1'b1;
         default: rx_st_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_st   <= S_IDLE;
         rx_cnt  <= '0;
         rx_bit  <= '0;
         rx_sh   <= '0;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
         rx_st   <= rx_st_n;
         rx_cnt  <= rx_cnt_n;
         rx_bit  <= rx_bit_n;
         rx_sh   <= rx_sh_n;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wp[AW-1:0]] <= rx_sh;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop)  rp <= rp + 1'b1;
      end
   end

   // ---------------- CON / IRQ ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_irq_en  <= 1'b0;
         rx_irq_en  <= 1'b0;
         tx_done    <= 1'b0;
         rx_overrun <= 1'b0;
         irq        <= 1'b0;
      end else begin
         if (wr && sel_con) begin
            tx_irq_en <= wdata[0];
            rx_irq_en <= wdata[1];
         end
         // set events take priority over the read-to-clear
         if (tx_done_set)      tx_done <= 1'b1;
         else if (con_rd)      tx_done <= 1'b0;
         if (overrun_set)      rx_overrun <= 1'b1;
         else if (con_rd)      rx_overrun <= 1'b0;
         irq <= (tx_irq_en & tx_done) | (rx_irq_en & ~empty);
      end
   end

   always_comb begin
      rdata = '0;
      if (sel_txd)
         rdata = {24'd0, tx_byte};
      else if (sel_rxd)
         rdata = empty ? 32'd0 : {24'd0, fifo_mem[rp[AW-1:0]]};
      else if (sel_con)
         rdata = {26'd0, rx_overrun, tx_busy, ~empty, tx_done, rx_irq_en, tx_irq_en};
   end

endmodule

// File: tb/tb_uart_mmio.sv
// Directed bench for uart_mmio with BAUD_DIV=16, FIFO_DEPTH=4.
// Inputs change on the falling clock edge; outputs are sampled there too.
module tb_uart_mmio;
   localparam int BD = 16;
   localparam logic [31:0] A_TXD = 32'h4000_0018;
   localparam logic [31:0] A_RXD = 32'h4000_001C;
   localparam logic [31:0] A_CON = 32'h4000_0020;

   logic        clk = 1'b0;
   logic        reset, rd, wr, rx;
   logic [31:0] addr, wdata, rdata;
   logic        irq, tx;

   int n_tests = 0;
   int n_fail  = 0;

   uart_mmio #(.BAUD_DIV(BD), .FIFO_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
      .rdata(rdata), .irq(irq), .tx(tx), .rx(rx)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      addr = a; wdata = d; wr = 1'b1;
      @(negedge clk);
      wr = 1'b0; addr = '0; wdata = '0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      @(negedge clk);
      addr = a; rd = 1'b1;
      #1 d = rdata;
      @(negedge clk);
      rd = 1'b0; addr = '0;
   endtask

   task automatic peek(input logic [31:0] a, output logic [31:0] d);
      addr = a;
      #1 d = rdata;
   endtask

   // start bit + 8 data bits; leaves rx high at the start of the stop bit
   task automatic rx_bits(input logic [7:0] b);
      rx = 1'b0;
      repeat (BD) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (BD) @(negedge clk);
      end
      rx = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_bits(b);
      repeat (BD) @(negedge clk);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] d;
      logic [7:0]  b;
      reset = 1'b0; rd = 1'b0; wr = 1'b0; rx = 1'b1; addr = '0; wdata = '0;
      repeat (3) @(negedge clk);

      // reset state
      check("rst_tx", tx, 1);
      check("rst_irq", irq, 0);
      peek(A_CON, d); check("rst_con", d, 0);
      peek(A_RXD, d); check("rst_rxd", d, 0);
      peek(A_TXD, d); check("rst_txd", d, 0);
      peek(32'h4000_0024, d); check("unmapped", d, 0);
      @(negedge clk); reset = 1'b1;
      repeat (2) @(negedge clk);

      // TX 0xA5: start on accept edge, 8 bits LSB first, stop, 160 busy cycles
      bus_write(A_TXD, 32'hA5);
      check("tx_start", tx, 0);
      peek(A_CON, d); check("tx_busy", d, 32'h10);
      b = 8'hA5;
      for (int i = 0; i < 8; i++) begin
         repeat (BD) @(negedge clk);
         check("tx_a5_bit", tx, b[i]);
      end
      repeat (BD) @(negedge clk);
      check("tx_stop", tx, 1);
      repeat (BD - 1) @(negedge clk);
      peek(A_CON, d); check("tx_busy_last", d, 32'h10);
      @(negedge clk);
      peek(A_CON, d); check("tx_done", d, 32'h04);
      peek(A_TXD, d); check("txd_rd", d, 32'hA5);
      bus_read(A_CON, d); check("con_rd_done", d, 32'h04);
      peek(A_CON, d); check("con_cleared", d, 0);

      // RX 0x3C
      send_byte(8'h3C);
      peek(A_CON, d); check("rx_avail", d, 32'h08);
      bus_read(A_RXD, d); check("rx_3c", d, 32'h3C);
      peek(A_CON, d); check("rx_popped", d, 0);
      peek(A_RXD, d); check("rx_empty", d, 0);

      // overrun: 5 bytes into a 4-deep FIFO
      for (int k = 1; k <= 5; k++) send_byte(8'(k));
      bus_read(A_CON, d); check("ovr_con", d, 32'h28);
      bus_read(A_CON, d); check("ovr_clr", d, 32'h08);
      for (int k = 1; k <= 4; k++) begin
         bus_read(A_RXD, d); check("ovr_data", d, 32'(k));
      end
      bus_read(A_RXD, d); check("pop_empty", d, 0);
      peek(A_CON, d); check("fifo_empty", d, 0);

      // RX irq timing: push happens 154.5 cycles after the start bit begins
      bus_write(A_CON, 32'h2);
      peek(A_CON, d); check("con_wr", d, 32'h02);
      rx_bits(8'h77);
      repeat (10) @(negedge clk);
      peek(A_CON, d); check("pre_push", d, 32'h02);
      check("irq_pre", irq, 0);
      @(negedge clk);
      peek(A_CON, d); check("post_push", d, 32'h0A);
      check("irq_lag", irq, 0);
      @(negedge clk);
      check("irq_set", irq, 1);
      repeat (4) @(negedge clk);
      bus_read(A_RXD, d); check("rx_77", d, 32'h77);
      check("irq_hold", irq, 1);
      @(negedge clk);
      check("irq_clr", irq, 0);
      bus_write(A_CON, 32'h0);

      // 8-cycle glitch is rejected; receiver still works afterwards
      rx = 1'b0;
      repeat (8) @(negedge clk);
      rx = 1'b1;
      repeat (30) @(negedge clk);
      peek(A_CON, d); check("glitch", d, 0);
      send_byte(8'h5A);
      bus_read(A_RXD, d); check("rx_5a", d, 32'h5A);

      // TXD write while busy is ignored
      bus_write(A_TXD, 32'h0F);
      repeat (40) @(negedge clk);
      bus_write(A_TXD, 32'h55);
      peek(A_TXD, d); check("busy_wr_txd", d, 32'h0F);
      peek(A_CON, d); check("busy_wr_con", d, 32'h10);
      repeat (6) @(negedge clk);
      b = 8'h0F;
      for (int i = 2; i < 8; i++) begin
         check("tx_0f_bit", tx, b[i]);
         repeat (BD) @(negedge clk);
      end
      check("tx_0f_stop", tx, 1);
      repeat (20) @(negedge clk);
      bus_read(A_CON, d); check("tx_0f_done", d, 32'h04);

      // reset during data bit 3
      bus_write(A_CON, 32'h3);
      bus_write(A_TXD, 32'hF0);
      repeat (64) @(negedge clk);
      check("tx_f0_bit3", tx, 0);
      reset = 1'b0;
      #1;
      check("mid_rst_tx", tx, 1);
      check("mid_rst_irq", irq, 0);
      peek(A_CON, d); check("mid_rst_con", d, 0);
      peek(A_TXD, d); check("mid_rst_txd", d, 0);
      @(negedge clk); reset = 1'b1;
      @(negedge clk);

      // fresh TX after reset, then a back-to-back write in the first idle cycle
      bus_write(A_TXD, 32'h3A);
      check("tx_3a_start", tx, 0);
      b = 8'h3A;
      for (int i = 0; i < 8; i++) begin
         repeat (BD) @(negedge clk);
         check("tx_3a_bit", tx, b[i]);
      end
      repeat (BD) @(negedge clk);
      check("tx_3a_stop", tx, 1);
      repeat (BD - 1) @(negedge clk);
      peek(A_CON, d); check("b2b_busy", d, 32'h10);
      bus_write(A_TXD, 32'hC3);
      check("b2b_start", tx, 0);
      peek(A_CON, d); check("b2b_con", d, 32'h14);
      peek(A_TXD, d); check("b2b_txd", d, 32'hC3);
      repeat (170) @(negedge clk);
      check("b2b_idle", tx, 1);
      bus_read(A_CON, d); check("b2b_done", d, 32'h04);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
